// File: rtl/fetch_flow_ctrl.sv
// Fetch flow control: tracks outstanding icache fetches, gates FIFO writes,
// sequences backend flushes and instruction barriers.
// Optional performance counters are enabled by defining FETCH_FLOW_PERF_EN.
module fetch_flow_ctrl #(
    parameter int unsigned MAX_OUTSTANDING = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if0_req_fire,
    input  logic        if1_rsp_valid,
    input  logic        fifo_allowin,
    input  logic        nearly_full,
    input  logic        fifo_valid,
    input  logic        bk_flush,
    input  logic [31:0] bk_flush_pc,
    input  logic        ibar_req,
    input  logic        icache_idle,
    output logic        fifo_readygo,
    output logic        fifo_flush,
    output logic        if0_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        ibar_done,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_drop_cnt
);

    localparam int unsigned CNT_W    = 2;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned PERF_W   = 32;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PC_W-1:0]  RESET_PC = 32'h1C00_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_IBAR  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic [CNT_W-1:0]   w_out_cnt_nxt;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic [CNT_W-1:0]   w_drop_cnt_nxt;
    logic [CNT_W-1:0]   w_drop_dec;
    logic [CNT_W-1:0]   w_drop_on_flush;
    logic               r_fifo_flush;
    logic               r_redirect_valid;
    logic [PC_W-1:0]    r_redirect_pc;
    logic               r_ibar_done;
    logic               w_ibar_done_nxt;
    logic               w_ibar_exit;
    logic               w_write_state;
    logic               w_drop_evt;

    // Combinational handshakes towards IF0 and the fetch FIFO
    assign w_write_state = (r_state == ST_RUN) || (r_state == ST_IBAR);
    assign if0_stall     = nearly_full || (r_out_cnt == MAX_CNT) ||
                           (r_state != ST_RUN) || bk_flush;
    assign fifo_readygo  = if1_rsp_valid && fifo_allowin && w_write_state && !bk_flush;

    assign fifo_flush     = r_fifo_flush;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign ibar_done      = r_ibar_done;

    assign w_ibar_exit = (r_state == ST_IBAR) && (r_out_cnt == '0) &&
                         !fifo_valid && icache_idle;
    assign w_drop_evt  = if1_rsp_valid &&
                         (bk_flush || (r_state == ST_FLUSH) || (r_state == ST_DRAIN));

    // Responses still owed at flush time, excluding the one discarded this cycle
    assign w_drop_on_flush = (if1_rsp_valid && (r_out_cnt != '0)) ?
                             r_out_cnt - CNT_W'(1) : r_out_cnt;
    assign w_drop_dec      = (if1_rsp_valid && (r_drop_cnt != '0)) ?
                             r_drop_cnt - CNT_W'(1) : r_drop_cnt;

    // Saturating outstanding-request counter
    always_comb begin
        w_out_cnt_nxt = r_out_cnt;
        if (if0_req_fire && !if1_rsp_valid && (r_out_cnt != MAX_CNT)) begin
            w_out_cnt_nxt = r_out_cnt + CNT_W'(1);
        end else if (!if0_req_fire && if1_rsp_valid && (r_out_cnt != '0)) begin
            w_out_cnt_nxt = r_out_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a flush overrides every other transition
    always_comb begin
        w_state_nxt     = r_state;
        w_drop_cnt_nxt  = r_drop_cnt;
        w_ibar_done_nxt = 1'b0;
        if (bk_flush) begin
            w_state_nxt    = ST_FLUSH;
            w_drop_cnt_nxt = w_drop_on_flush;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (ibar_req) begin
                        w_state_nxt = ST_IBAR;
                    end
                end
                ST_FLUSH: begin
                    w_drop_cnt_nxt = w_drop_dec;
                    w_state_nxt    = (w_drop_dec != '0) ? ST_DRAIN : ST_RUN;
                end
                ST_DRAIN: begin
                    w_drop_cnt_nxt = w_drop_dec;
                    if (w_drop_dec == '0) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_IBAR: begin
                    if (w_ibar_exit) begin
                        w_state_nxt     = ST_RUN;
                        w_ibar_done_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_cnt        <= '0;
            r_drop_cnt       <= '0;
            r_fifo_flush     <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= RESET_PC;
            r_ibar_done      <= 1'b0;
        end else begin
            r_out_cnt        <= w_out_cnt_nxt;
            r_drop_cnt       <= w_drop_cnt_nxt;
            r_fifo_flush     <= bk_flush;
            r_redirect_valid <= bk_flush;
            r_ibar_done      <= w_ibar_done_nxt;
            if (bk_flush) begin
                r_redirect_pc <= bk_flush_pc;
            end
        end
    end

`ifdef FETCH_FLOW_PERF_EN
    logic [PERF_W-1:0] r_perf_stall_cnt;
    logic [PERF_W-1:0] r_perf_drop_cnt;

    // Free-running counters, wrapping naturally
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_stall_cnt <= '0;
            r_perf_drop_cnt  <= '0;
        end else begin
            if (if0_stall) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + PERF_W'(1);
            end
            if (w_drop_evt) begin
                r_perf_drop_cnt <= r_perf_drop_cnt + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_drop_cnt  = r_perf_drop_cnt;
`else
    logic w_unused_perf;
    assign w_unused_perf  = w_drop_evt;
    assign perf_stall_cnt = '0;
    assign perf_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_flow_ctrl.sv
// Directed scoreboard bench for fetch_flow_ctrl: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_fetch_flow_ctrl;

    localparam int M_ST = 1;
    localparam int M_RG = 2;
    localparam int M_FF = 4;
    localparam int M_RV = 8;
    localparam int M_PC = 16;
    localparam int M_ID = 32;
    localparam int M_PS = 64;
    localparam int M_PD = 128;
    localparam int M_B  = M_ST | M_RG | M_FF | M_RV | M_ID;
    localparam int M_BP = M_B | M_PC;
    localparam int M_AL = 255;
`ifdef FETCH_FLOW_PERF_EN
    localparam logic [31:0] PERF_ON = 32'd1;
`else
    localparam logic [31:0] PERF_ON = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        if0_req_fire = 1'b0;
    logic        if1_rsp_valid = 1'b0;
    logic        fifo_allowin = 1'b1;
    logic        nearly_full = 1'b0;
    logic        fifo_valid = 1'b0;
    logic        bk_flush = 1'b0;
    logic [31:0] bk_flush_pc = '0;
    logic        ibar_req = 1'b0;
    logic        icache_idle = 1'b1;
    logic        fifo_readygo;
    logic        fifo_flush;
    logic        if0_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ibar_done;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_drop_cnt;

    typedef struct {
        int          step;
        int          mask;
        logic        st;
        logic        rg;
        logic        ff;
        logic        rv;
        logic [31:0] pc;
        logic        ibd;
        logic [31:0] ps;
        logic [31:0] pd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    fetch_flow_ctrl #(.MAX_OUTSTANDING(3)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .if0_req_fire   (if0_req_fire),
        .if1_rsp_valid  (if1_rsp_valid),
        .fifo_allowin   (fifo_allowin),
        .nearly_full    (nearly_full),
        .fifo_valid     (fifo_valid),
        .bk_flush       (bk_flush),
        .bk_flush_pc    (bk_flush_pc),
        .ibar_req       (ibar_req),
        .icache_idle    (icache_idle),
        .fifo_readygo   (fifo_readygo),
        .fifo_flush     (fifo_flush),
        .if0_stall      (if0_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ibar_done      (ibar_done),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int stp, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, stp, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if ((e.mask & M_ST) != 0) cmp("if0_stall", e.step, 32'(if0_stall), 32'(e.st));
                if ((e.mask & M_RG) != 0) cmp("fifo_readygo", e.step, 32'(fifo_readygo), 32'(e.rg));
                if ((e.mask & M_FF) != 0) cmp("fifo_flush", e.step, 32'(fifo_flush), 32'(e.ff));
                if ((e.mask & M_RV) != 0) cmp("redirect_valid", e.step, 32'(redirect_valid), 32'(e.rv));
                if ((e.mask & M_PC) != 0) cmp("redirect_pc", e.step, redirect_pc, e.pc);
                if ((e.mask & M_ID) != 0) cmp("ibar_done", e.step, 32'(ibar_done), 32'(e.ibd));
                if ((e.mask & M_PS) != 0) cmp("perf_stall_cnt", e.step, perf_stall_cnt, e.ps);
                if ((e.mask & M_PD) != 0) cmp("perf_drop_cnt", e.step, perf_drop_cnt, e.pd);
            end
        end
    end

    // Advance one cycle and restore idle inputs (rstn untouched)
    task automatic nx();
        @(posedge clk);
        #1;
        if0_req_fire  = 1'b0;
        if1_rsp_valid = 1'b0;
        fifo_allowin  = 1'b1;
        nearly_full   = 1'b0;
        fifo_valid    = 1'b0;
        bk_flush      = 1'b0;
        bk_flush_pc   = '0;
        ibar_req      = 1'b0;
        icache_idle   = 1'b1;
    endtask

    task automatic ex(input int m, input logic st, input logic rg, input logic ff, input logic rv,
                      input logic [31:0] pc, input logic ibd, input logic [31:0] ps, input logic [31:0] pd);
        exp_t e;
        e.step = step; e.mask = m; e.st = st; e.rg = rg; e.ff = ff; e.rv = rv;
        e.pc = pc; e.ibd = ibd; e.ps = ps; e.pd = pd;
        q.push_back(e);
        step++;
    endtask

    task automatic flush_to(input logic [31:0] pc, input logic rsp);
        bk_flush = 1'b1; bk_flush_pc = pc; if1_rsp_valid = rsp;
    endtask

    initial begin
        int wait_cyc;
        // Reset values
        nx(); ex(M_AL, 0, 0, 0, 0, 32'h1C000000, 0, 0, 0);
        // Three fires saturate the outstanding count, one response releases it
        nx(); rstn = 1'b1; if0_req_fire = 1'b1; ex(M_B, 0, 0, 0, 0, 0, 0, 0, 0);
        nx(); if0_req_fire = 1'b1;              ex(M_B, 0, 0, 0, 0, 0, 0, 0, 0);
        nx(); if0_req_fire = 1'b1;              ex(M_B, 0, 0, 0, 0, 0, 0, 0, 0);
        nx();                                   ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx(); if1_rsp_valid = 1'b1;             ex(M_B, 1, 1, 0, 0, 0, 0, 0, 0);
        nx();                                   ex(M_B, 0, 0, 0, 0, 0, 0, 0, 0);
        // Flush with a coincident response, one left to drain
        nx(); flush_to(32'h1C000100, 1'b1);     ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx();                                   ex(M_BP, 1, 0, 1, 1, 32'h1C000100, 0, 0, 0);
        nx();                                   ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx(); if1_rsp_valid = 1'b1;             ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx();                                   ex(M_BP, 0, 0, 0, 0, 32'h1C000100, 0, 0, 0);
        // Flush with nothing outstanding goes straight back to RUN
        nx(); flush_to(32'h1C000180, 1'b0);     ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx();                                   ex(M_BP, 1, 0, 1, 1, 32'h1C000180, 0, 0, 0);
        nx(); if0_req_fire = 1'b1; if1_rsp_valid = 1'b1; ex(M_B, 0, 1, 0, 0, 0, 0, 0, 0);
        // Barrier held off by a non-empty FIFO
        nx(); ibar_req = 1'b1; fifo_valid = 1'b1; ex(M_B, 0, 0, 0, 0, 0, 0, 0, 0);
        nx(); ibar_req = 1'b1; fifo_valid = 1'b1; ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx(); ibar_req = 1'b1; fifo_valid = 1'b1; if1_rsp_valid = 1'b1; ex(M_B, 1, 1, 0, 0, 0, 0, 0, 0);
        nx(); ibar_req = 1'b1; fifo_valid = 1'b1; ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx(); ibar_req = 1'b1; fifo_valid = 1'b1; ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx(); ibar_req = 1'b1;                  ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx();                                   ex(M_B, 0, 0, 0, 0, 0, 1, 0, 0);
        nx();                                   ex(M_B, 0, 0, 0, 0, 0, 0, 0, 0);
        // Flush beats barrier completion; no done pulse
        nx(); ibar_req = 1'b1;                  ex(M_B, 0, 0, 0, 0, 0, 0, 0, 0);
        nx(); ibar_req = 1'b1; flush_to(32'h1C0001C0, 1'b0); ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx();                                   ex(M_BP, 1, 0, 1, 1, 32'h1C0001C0, 0, 0, 0);
        nx(); if0_req_fire = 1'b1;              ex(M_B, 0, 0, 0, 0, 0, 0, 0, 0);
        nx(); if0_req_fire = 1'b1;              ex(M_B, 0, 0, 0, 0, 0, 0, 0, 0);
        nx(); if0_req_fire = 1'b1;              ex(M_B, 0, 0, 0, 0, 0, 0, 0, 0);
        // Nested flushes during FLUSH/DRAIN; last target wins
        nx(); flush_to(32'h1C0000F0, 1'b0);     ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx(); if1_rsp_valid = 1'b1;             ex(M_BP, 1, 0, 1, 1, 32'h1C0000F0, 0, 0, 0);
        nx(); flush_to(32'h1C000200, 1'b0);     ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx();                                   ex(M_BP, 1, 0, 1, 1, 32'h1C000200, 0, 0, 0);
        nx(); flush_to(32'h1C000300, 1'b1);     ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx();                                   ex(M_BP, 1, 0, 1, 1, 32'h1C000300, 0, 0, 0);
        nx();                                   ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx(); if1_rsp_valid = 1'b1;             ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx();                                   ex(M_BP, 0, 0, 0, 0, 32'h1C000300, 0, 0, 0);
        // Reset asserted mid-DRAIN
        nx(); if0_req_fire = 1'b1;              ex(M_B, 0, 0, 0, 0, 0, 0, 0, 0);
        nx(); if0_req_fire = 1'b1;              ex(M_B, 0, 0, 0, 0, 0, 0, 0, 0);
        nx(); flush_to(32'h1C000400, 1'b0);     ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        nx();                                   ex(M_BP, 1, 0, 1, 1, 32'h1C000400, 0, 0, 0);
        nx();                                   ex(M_B | M_PD, 1, 0, 0, 0, 0, 0, 0, PERF_ON * 32'd5);
        nx(); rstn = 1'b0;                      ex(M_AL, 0, 0, 0, 0, 32'h1C000000, 0, 0, 0);
        nx(); rstn = 1'b1;                      ex(M_AL, 0, 0, 0, 0, 32'h1C000000, 0, 0, 0);
        // Five stalled cycles, then a response refused by a full FIFO
        for (int i = 0; i < 5; i++) begin
            nx(); nearly_full = 1'b1;           ex(M_B, 1, 0, 0, 0, 0, 0, 0, 0);
        end
        nx(); fifo_allowin = 1'b0; if1_rsp_valid = 1'b1;
        ex(M_AL, 0, 0, 0, 0, 32'h1C000000, 0, PERF_ON * 32'd5, 0);
        nx();

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=%0d want=0 pending", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
